// File: rtl/frame_scan_pkg.sv
// Shared types and constants for the 3x3 filter frame-scan controller.
package frame_scan_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRIME = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } scan_state_e;

    localparam int BRD_TOP   = 3;
    localparam int BRD_BOT   = 2;
    localparam int BRD_LEFT  = 1;
    localparam int BRD_RIGHT = 0;

    function automatic int frame_pixels(input int w, input int h);
        return w * h;
    endfunction

    // Reads needed before the first 3x3 window centre is complete.
    function automatic int lead_count(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/frame_scan_ctrl_pipe.sv
// scan_delay_pipe: enable-gated shift register carrying {valid, addr} through DEPTH stages.
module scan_delay_pipe #(
    parameter int DEPTH  = 3,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr
);

    logic [DEPTH-1:0]  valid_r;
    logic [ADDR_W-1:0] addr_r [DEPTH];

    // Shift stage contents forward only on enabled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i] <= 1'b0;
                addr_r[i]  <= {ADDR_W{1'b0}};
            end
        end else if (en) begin
            valid_r[0] <= in_valid;
            addr_r[0]  <= in_addr;
            for (int i = 1; i < DEPTH; i++) begin
                valid_r[i] <= valid_r[i-1];
                addr_r[i]  <= addr_r[i-1];
            end
        end
    end

    assign out_valid = valid_r[DEPTH-1];
    assign out_addr  = addr_r[DEPTH-1];

endmodule

// File: rtl/frame_scan_ctrl.sv
// Raster-scan sequencer for the 3x3 filter: read addresses, window flags and write strobes.
// Optional SCAN_STATS_EN adds stall_cycles and frame_count outputs.
module frame_scan_ctrl
    import frame_scan_pkg::*;
#(
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256,
    parameter int ADDR_W     = 16,
    parameter int FILTER_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              act,
    output logic              win_valid,
    output logic [3:0]        win_border,
    output logic              wr_en,
`ifdef SCAN_STATS_EN
    output logic [31:0]       stall_cycles,
    output logic [15:0]       frame_count,
`endif
    output logic [ADDR_W-1:0] wr_addr
);

    localparam int P    = frame_pixels(IMG_W, IMG_H);
    localparam int LEAD = lead_count(IMG_W);
    localparam int XW   = $clog2(IMG_W);
    localparam int YW   = $clog2(IMG_H);
    localparam int DW   = (FILTER_LAT > 1) ? $clog2(FILTER_LAT) : 1;

    localparam logic [ADDR_W-1:0] P_LAST    = ADDR_W'(P - 1);
    localparam logic [ADDR_W-1:0] LEAD_LAST = ADDR_W'(LEAD - 1);
    localparam logic [XW-1:0]     X_LAST    = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     Y_LAST    = YW'(IMG_H - 1);
    localparam logic [DW-1:0]     D_LAST    = DW'(FILTER_LAT - 1);

    scan_state_e       state_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W-1:0] cen_r;
    logic [XW-1:0]     cx_r;
    logic [YW-1:0]     cy_r;
    logic [DW-1:0]     drain_r;

    logic              act_s;
    logic              centre_s;
    logic [3:0]        border_s;
    logic              pipe_valid_s;
    logic [ADDR_W-1:0] pipe_addr_s;

    // Decide whether this cycle advances the scan and whether it emits a centre.
    always_comb begin
        act_s    = 1'b0;
        centre_s = 1'b0;
        border_s = 4'b0000;
        if (out_ready) begin
            case (state_r)
                PRIME, RUN, FLUSH, DRAIN: act_s = 1'b1;
                default:                  act_s = 1'b0;
            endcase
        end else begin
            act_s = 1'b0;
        end
        if (act_s && ((state_r == RUN) || (state_r == FLUSH))) begin
            centre_s = 1'b1;
        end else begin
            centre_s = 1'b0;
        end
        border_s[BRD_TOP]   = (cy_r == {YW{1'b0}});
        border_s[BRD_BOT]   = (cy_r == Y_LAST);
        border_s[BRD_LEFT]  = (cx_r == {XW{1'b0}});
        border_s[BRD_RIGHT] = (cx_r == X_LAST);
    end

    scan_delay_pipe #(
        .DEPTH  (FILTER_LAT),
        .ADDR_W (ADDR_W)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .en        (act_s),
        .in_valid  (centre_s),
        .in_addr   (cen_r),
        .out_valid (pipe_valid_s),
        .out_addr  (pipe_addr_s)
    );

    // Scan FSM with counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            rd_ptr_r   <= {ADDR_W{1'b0}};
            cen_r      <= {ADDR_W{1'b0}};
            cx_r       <= {XW{1'b0}};
            cy_r       <= {YW{1'b0}};
            drain_r    <= {DW{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= {ADDR_W{1'b0}};
            act        <= 1'b0;
            win_valid  <= 1'b0;
            win_border <= 4'b0000;
            wr_en      <= 1'b0;
            wr_addr    <= {ADDR_W{1'b0}};
        end else begin
            busy       <= (state_r != IDLE);
            done       <= 1'b0;
            rd_en      <= 1'b0;
            act        <= act_s;
            win_valid  <= centre_s;
            win_border <= centre_s ? border_s : 4'b0000;
            wr_en      <= act_s && pipe_valid_s;
            if (act_s && pipe_valid_s) begin
                wr_addr <= pipe_addr_s;
            end

            if (centre_s) begin
                cen_r <= cen_r + ADDR_W'(1);
                if (cx_r == X_LAST) begin
                    cx_r <= {XW{1'b0}};
                    cy_r <= (cy_r == Y_LAST) ? {YW{1'b0}} : cy_r + YW'(1);
                end else begin
                    cx_r <= cx_r + XW'(1);
                end
            end

            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r  <= PRIME;
                        rd_ptr_r <= {ADDR_W{1'b0}};
                        cen_r    <= {ADDR_W{1'b0}};
                        cx_r     <= {XW{1'b0}};
                        cy_r     <= {YW{1'b0}};
                        drain_r  <= {DW{1'b0}};
                    end
                end
                PRIME: begin
                    if (out_ready) begin
                        rd_en    <= 1'b1;
                        rd_addr  <= rd_ptr_r;
                        rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
                        if (rd_ptr_r == LEAD_LAST) begin
                            state_r <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        rd_en    <= 1'b1;
                        rd_addr  <= rd_ptr_r;
                        rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
                        if (rd_ptr_r == P_LAST) begin
                            state_r <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (out_ready && (cen_r == P_LAST)) begin
                        state_r <= DRAIN;
                        drain_r <= {DW{1'b0}};
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (drain_r == D_LAST) begin
                            state_r <= DONE;
                        end else begin
                            drain_r <= drain_r + DW'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        done    <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

`ifdef SCAN_STATS_EN
    // Stall and completed-frame statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 32'd0;
            frame_count  <= 16'd0;
        end else begin
            if ((state_r == IDLE) && start) begin
                stall_cycles <= 32'd0;
            end else if ((state_r != IDLE) && !out_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if ((state_r == DONE) && out_ready) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end
`endif

endmodule
